// File: rtl/clock_gate_pkg.sv
// Shared types for the gated-clock request chain: leaf FSM states and upstream status.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package clock_gate_pkg;

    // Leaf requester FSM encoding, also exported on the debug state port
    typedef enum logic [2:0] {
        LEAF_OFF  = 3'd0,
        LEAF_WAKE = 3'd1,
        LEAF_ON   = 3'd2,
        LEAF_IDLE = 3'd3,
        LEAF_STOP = 3'd4,
        LEAF_HOLD = 3'd5
    } leaf_state_e;

    // Status reported by the upstream gate stage
    typedef struct packed {
        logic ready;
        logic silent;
        logic starting;
        logic stopping;
    } parent_status_t;

    localparam int WAKE_CNT_W = 16;

    // States in which the upstream request is held high
    function automatic logic state_requests(input leaf_state_e s);
        return (s == LEAF_WAKE) || (s == LEAF_ON) || (s == LEAF_IDLE);
    endfunction

endpackage

// File: rtl/clock_idle_timer.sv
// Shared down-counter for idle release and stop hold-off, with a registered expiry flag.
// Latency: expiry flag rises one decrement after the count has reached zero.
// Backpressure: none; load has priority over decrement.
module clock_idle_timer #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         async_resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q, zero_d;

    // Load restarts the period; a decrement requested at zero marks the period as spent,
    // so the terminal count of zero still occupies a full cycle.
    always_comb begin
        cnt_d  = cnt_q;
        zero_d = zero_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            zero_d = 1'b0;
        end else if (dec_i) begin
            zero_d = (cnt_q == '0);
            if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Counter and expiry flag registers
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/clock_leaf_requester.sv
// Leaf-side gated-clock requester: wakes on local work, releases after an idle period, holds off after stop.
// Latency: parent_request one cycle after work is sampled in OFF; work_grant combinational on state and parent_ready.
// Backpressure: waits for parent_silent before re-requesting; ignores local work during the hold-off.
module clock_leaf_requester
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES    = 16,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  async_resetn,
    input  logic                  work_request,
    output logic                  work_grant,
    output logic                  parent_request,
    input  logic                  parent_ready,
    input  logic                  parent_silent,
    input  logic                  parent_starting,
    input  logic                  parent_stopping,
    output logic [2:0]            state_o,
    output logic [WAKE_CNT_W-1:0] wake_count
);

    localparam int MAX_CYC = (IDLE_CYCLES > HOLDOFF_CYCLES) ? IDLE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    parent_status_t par;
    leaf_state_e    state_q, state_d;
    logic           req_q, req_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic           tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_load_val;

    assign par = {parent_ready, parent_silent, parent_starting, parent_stopping};

    clock_idle_timer #(.W(CNT_W)) u_timer (
        .clock        (clock),
        .async_resetn (async_resetn),
        .load_i       (tmr_load),
        .load_val_i   (tmr_load_val),
        .dec_i        (tmr_dec),
        .zero_o       (tmr_zero)
    );

    // State and registered request; reset drops request immediately
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state_q <= LEAF_OFF;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Next state plus timer load/decrement on the transitions that own the shared counter
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state_q)
            LEAF_OFF: begin
                // Only wake once the upstream is fully quiet, never mid start/stop
                if (work_request && par.silent && !par.starting && !par.stopping) begin
                    state_d = LEAF_WAKE;
                end
            end
            LEAF_WAKE: begin
                if (par.ready) begin
                    state_d = LEAF_ON;
                end
            end
            LEAF_ON: begin
                if (!par.ready) begin
                    state_d = LEAF_WAKE;
                end else if (!work_request) begin
                    state_d      = LEAF_IDLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = IDLE_LOAD;
                end
            end
            LEAF_IDLE: begin
                // Lost clock beats everything; returning work beats expiry
                if (!par.ready) begin
                    state_d = LEAF_WAKE;
                end else if (work_request) begin
                    state_d = LEAF_ON;
                end else if (tmr_zero) begin
                    state_d = LEAF_STOP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            LEAF_STOP: begin
                if (par.silent) begin
                    state_d      = LEAF_HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end
            end
            LEAF_HOLD: begin
                // Pending work waits in OFF so the upstream never sees chatter
                if (tmr_zero) begin
                    state_d = LEAF_OFF;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = LEAF_OFF;
        endcase
    end

    // Outputs: registered request follows next state, grant only while running and upstream ready
    always_comb begin
        req_d      = state_requests(state_d);
        work_grant = ((state_q == LEAF_ON) || (state_q == LEAF_IDLE)) && par.ready;
        wake_cnt_d = wake_cnt_q;
        if ((state_q == LEAF_OFF) && (state_d == LEAF_WAKE) && (wake_cnt_q != '1)) begin
            wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        end
    end

    // Saturating wake counter
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            wake_cnt_q <= '0;
        end else begin
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign parent_request = req_q;
    assign state_o        = state_q;
    assign wake_count     = wake_cnt_q;

endmodule

// File: tb/tb_clock_leaf_requester.sv
// Bench for clock_leaf_requester: behavioural upstream gate plus an event-level reference model.
// Latency: checks request/wake_count 1 time unit after each edge, grant after inputs settle.
// Backpressure: upstream start/stop latency configurable; ready and silent can be overridden.
module tb_clock_leaf_requester;
    import clock_gate_pkg::*;

    localparam int IDLE      = 16;
    localparam int HOLDOFF   = 4;
    localparam int START_LAT = 3;
    localparam int STOP_LAT  = 2;

    logic        clock = 1'b0;
    logic        async_resetn;
    logic        work_request;
    logic        work_grant;
    logic        parent_request;
    logic        parent_ready;
    logic        parent_silent;
    logic        parent_starting;
    logic        parent_stopping;
    logic [2:0]  state_o;
    logic [15:0] wake_count;

    int errors = 0;
    int checks = 0;

    // Upstream gate model
    bit u_ready, u_silent, u_starting, u_stopping;
    int u_cnt;
    bit kill_ready, busy_ovr;

    // Reference model: request level, running phase, waiting-for-silent, low-work run, hold remaining
    bit m_req, m_run, m_stop;
    int m_low, m_hold, m_wakes;

    always #5 clock = ~clock;

    clock_leaf_requester #(.IDLE_CYCLES(IDLE), .HOLDOFF_CYCLES(HOLDOFF)) dut (
        .clock           (clock),
        .async_resetn    (async_resetn),
        .work_request    (work_request),
        .work_grant      (work_grant),
        .parent_request  (parent_request),
        .parent_ready    (parent_ready),
        .parent_silent   (parent_silent),
        .parent_starting (parent_starting),
        .parent_stopping (parent_stopping),
        .state_o         (state_o),
        .wake_count      (wake_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_up();
        parent_ready    = u_ready && !kill_ready;
        parent_silent   = u_silent && !busy_ovr;
        parent_starting = u_starting;
        parent_stopping = u_stopping || busy_ovr;
    endtask

    task automatic upstream_reset();
        u_ready = 0; u_silent = 1; u_starting = 0; u_stopping = 0; u_cnt = 0;
        kill_ready = 0; busy_ovr = 0;
    endtask

    task automatic upstream_step();
        if (u_starting) begin
            if (u_cnt > 1) u_cnt--;
            else begin u_starting = 0; u_ready = 1; end
        end else if (u_stopping) begin
            if (u_cnt > 1) u_cnt--;
            else begin u_stopping = 0; u_silent = 1; end
        end else if (u_silent && parent_request) begin
            u_silent = 0; u_starting = 1; u_cnt = START_LAT;
        end else if (u_ready && !parent_request) begin
            u_ready = 0; u_stopping = 1; u_cnt = STOP_LAT;
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_run = 0; m_stop = 0; m_low = 0; m_hold = 0; m_wakes = 0;
    endtask

    // One clock edge of the leaf rules, using the inputs sampled at that edge
    task automatic model_edge(input bit w, input bit rdy, input bit sil, input bit sta, input bit sto);
        if (m_hold > 0) begin
            m_hold--;                                // hold-off ignores work
        end else if (m_stop) begin
            if (sil) begin m_stop = 0; m_hold = HOLDOFF + 1; end
        end else if (!m_req) begin
            if (w && sil && !sta && !sto) begin
                m_req = 1; m_run = 0;
                if (m_wakes < 65535) m_wakes++;
            end
        end else if (!m_run) begin
            if (rdy) begin m_run = 1; m_low = 0; end
        end else if (!rdy) begin
            m_run = 0;
        end else if (w) begin
            m_low = 0;
        end else begin
            // release on the low sample IDLE+1 edges after the first one
            m_low++;
            if (m_low == IDLE + 2) begin m_req = 0; m_run = 0; m_stop = 1; end
        end
    endtask

    task automatic step();
        bit w, r, si, st, sp;
        w = work_request; r = parent_ready; si = parent_silent;
        st = parent_starting; sp = parent_stopping;
        @(posedge clock);
        #1;
        model_edge(w, r, si, st, sp);
        chk("request", parent_request, m_req);
        chk("wake_count", wake_count, m_wakes);
        upstream_step();
        apply_up();
        #1;
        chk("grant", work_grant, m_run && parent_ready);
    endtask

    initial begin
        int n;
        int run;

        // Reset state
        async_resetn = 0;
        work_request = 0;
        upstream_reset();
        model_reset();
        apply_up();
        #12;
        chk("rst_request", parent_request, 0);
        chk("rst_grant", work_grant, 0);
        chk("rst_state", state_o, LEAF_OFF);
        chk("rst_wakes", wake_count, 0);
        async_resetn = 1;

        // First wake: request one edge after sampling, grant one edge after ready
        work_request = 1;
        step();
        chk("wake_req", parent_request, 1);
        n = 0;
        while (!work_grant && n < 20) begin step(); n++; end
        chk("grant_latency", n, 4);
        chk("wake_count_1", wake_count, 1);
        chk("state_on", state_o, LEAF_ON);

        // Short idle gap never releases the clock
        work_request = 0;
        repeat (10) step();
        chk("state_idle", state_o, LEAF_IDLE);
        work_request = 1;
        step();
        chk("back_on", state_o, LEAF_ON);
        chk("grant_kept", work_grant, 1);

        // Permanent release: falls after edge t+IDLE+1, then hold-off before re-wake
        work_request = 0;
        n = 0;
        do begin step(); n++; end while (parent_request && n < 40);
        chk("release_steps", n, IDLE + 2);
        chk("release_grant", work_grant, 0);
        work_request = 1;
        n = 0;
        while (!parent_silent && n < 20) begin step(); n++; end
        chk("silent_seen", parent_silent, 1);
        n = 0;
        while (!parent_request && n < 30) begin step(); n++; end
        chk("holdoff_min", (n > HOLDOFF) && parent_request, 1);
        chk("wake_count_2", wake_count, 2);
        n = 0;
        while (!work_grant && n < 20) begin step(); n++; end
        chk("grant_again", work_grant, 1);

        // Upstream drops ready while ON
        kill_ready = 1;
        apply_up();
        #1;
        chk("grant_drop_same_cycle", work_grant, 0);
        step();
        chk("state_wake", state_o, LEAF_WAKE);
        chk("req_held", parent_request, 1);
        kill_ready = 0;
        apply_up();
        step();
        chk("grant_resume", work_grant, 1);
        chk("state_on_again", state_o, LEAF_ON);

        // Work arrives while the upstream is still stopping
        work_request = 0;
        n = 0;
        while (state_o != LEAF_OFF && n < 80) begin step(); n++; end
        chk("reach_off", state_o, LEAF_OFF);
        busy_ovr = 1;
        work_request = 1;
        apply_up();
        repeat (3) begin
            step();
            chk("req_while_stopping", parent_request, 0);
        end
        busy_ovr = 0;
        apply_up();
        step();
        chk("req_after_silent", parent_request, 1);
        chk("wake_count_3", wake_count, 3);

        // Randomized work with occasional ready loss and upstream busy periods
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                work_request = ($urandom_range(0, 1) == 1);
                run = $urandom_range(1, 40);
            end
            run--;
            if (kill_ready) kill_ready = ($urandom_range(0, 2) != 0);
            else            kill_ready = ($urandom_range(0, 59) == 0);
            if (busy_ovr) busy_ovr = ($urandom_range(0, 3) != 0);
            else          busy_ovr = u_silent && ($urandom_range(0, 39) == 0);
            apply_up();
            step();
        end

        // Asynchronous reset in the middle of IDLE
        kill_ready = 0;
        busy_ovr = 0;
        work_request = 1;
        apply_up();
        n = 0;
        while (!work_grant && n < 100) begin step(); n++; end
        chk("pre_reset_grant", work_grant, 1);
        work_request = 0;
        repeat (5) step();
        chk("pre_reset_idle", state_o, LEAF_IDLE);
        async_resetn = 0;
        #1;
        chk("arst_request", parent_request, 0);
        chk("arst_grant", work_grant, 0);
        chk("arst_state", state_o, LEAF_OFF);
        chk("arst_wakes", wake_count, 0);
        model_reset();
        upstream_reset();
        apply_up();
        #20;
        async_resetn = 1;
        #1;
        chk("post_reset_state", state_o, LEAF_OFF);
        chk("post_reset_wakes", wake_count, 0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
